axis_rr_arbiter: RTL

Round-robin AXI4-Stream arbiter that shares one downstream stream path, typically an axis pipeline register chain feeding the engine, between S_COUNT upstream requesters. Selects one requester at a time, holds the grant for a whole packet (or a single beat, per configuration), and forwards beats through one registered output stage tagged with the source index. Sits between the DMA/stream sources and the shared pipeline register chain.

---
 rtl/axis_rr_arbiter.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/axis_rr_arbiter.sv
// Round-robin AXI4-Stream arbiter with one registered output stage.
// Define AXIS_ARB_PACKET_LOCK_EN to hold each grant for a whole packet.
module axis_rr_arbiter #(
  parameter int S_COUNT    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 1,
  parameter int ID_WIDTH   = $clog2(S_COUNT)
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [S_COUNT-1:0]            s_axis_tvalid,
  output logic [S_COUNT-1:0]            s_axis_tready,
  input  logic [S_COUNT-1:0]            s_axis_tlast,
  input  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [USER_WIDTH-1:0]         m_axis_tuser,
  output logic [ID_WIDTH-1:0]           m_axis_tid,
  output logic                          grant_valid,
  output logic [ID_WIDTH-1:0]           grant_index
);

`ifdef AXIS_ARB_PACKET_LOCK_EN
  localparam bit LockEn = 1'b1;
`else
  localparam bit LockEn = 1'b0;
`endif

  typedef enum logic {
    IDLE,
    GRANTED
  } state_e;

  state_e                state_q, state_d;
  logic [ID_WIDTH-1:0]   grant_q, grant_d;
  logic                  in_pkt_q, in_pkt_d;

  logic                  out_vld_q, out_vld_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_last_q, out_last_d;
  logic [USER_WIDTH-1:0] out_user_q, out_user_d;
  logic [ID_WIDTH-1:0]   out_id_q, out_id_d;

  logic                  sel_vld;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [USER_WIDTH-1:0] sel_user;
  logic                  others_vld;

  logic                  granted;
  logic                  out_free;
  logic                  accept;
  logic                  end_grant;
  logic                  idle_rel;
  logic                  arb;

  logic [ID_WIDTH-1:0]   win;
  logic                  win_found;

  assign granted  = (state_q == GRANTED);
  assign out_free = !out_vld_q || m_axis_tready;

  always_comb begin
    sel_vld    = 1'b0;
    sel_last   = 1'b0;
    sel_data   = '0;
    sel_user   = '0;
    others_vld = 1'b0;
    for (int i = 0; i < S_COUNT; i++) begin
      if (grant_q == ID_WIDTH'(i)) begin
        sel_vld  = s_axis_tvalid[i];
        sel_last = s_axis_tlast[i];
        sel_data = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_user = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
      end else if (s_axis_tvalid[i]) begin
        others_vld = 1'b1;
      end
    end
  end

  always_comb begin
    s_axis_tready = '0;
    for (int i = 0; i < S_COUNT; i++) begin
      s_axis_tready[i] = granted && out_free
                         && (grant_q == ID_WIDTH'(i));
    end
  end

  assign accept    = granted && out_free && sel_vld;
  assign end_grant = accept && (sel_last || !LockEn);

  // An idle holder gives way, unless it is locked mid-packet.
  assign idle_rel = granted && !sel_vld && others_vld
                    && !(LockEn && in_pkt_q);

  assign arb = (!granted && (|s_axis_tvalid))
               || end_grant || idle_rel;

  // Scan g+1, g+2, ... wrapping; the current holder comes last.
  always_comb begin
    int idx;
    idx       = 0;
    win       = grant_q;
    win_found = 1'b0;
    for (int k = 1; k <= S_COUNT; k++) begin
      idx = (int'(grant_q) + k) % S_COUNT;
      if (!win_found && s_axis_tvalid[ID_WIDTH'(idx)]) begin
        win       = ID_WIDTH'(idx);
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    if (arb && win_found) begin
      state_d = GRANTED;
      grant_d = win;
    end
  end

  assign in_pkt_d = accept ? !sel_last : in_pkt_q;

  always_comb begin
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    out_user_d = out_user_q;
    out_id_d   = out_id_q;
    if (accept) begin
      out_vld_d  = 1'b1;
      out_data_d = sel_data;
      out_last_d = sel_last;
      out_user_d = sel_user;
      out_id_d   = grant_q;
    end else if (m_axis_tready) begin
      out_vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      grant_q <= ID_WIDTH'(S_COUNT - 1);
      in_pkt_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      in_pkt_q <= in_pkt_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      out_user_q <= '0;
      out_id_q   <= '0;
    end else begin
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
      out_user_q <= out_user_d;
      out_id_q   <= out_id_d;
    end
  end

  assign m_axis_tvalid = out_vld_q;
  assign m_axis_tdata  = out_data_q;
  assign m_axis_tlast  = out_last_q;
  assign m_axis_tuser  = out_user_q;
  assign m_axis_tid    = out_id_q;
  assign grant_valid   = granted;
  assign grant_index   = grant_q;

endmodule
